// File: rtl/cpu_pkg.sv
// Opcode constants, FSM state and instruction-class encodings for the control sequencer.
// CTRL_STEP_EN adds the WAIT state used for single-step operation.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef CTRL_STEP_EN
        , S_WAIT
`endif
    } state_e;

`ifdef CTRL_STEP_EN
    localparam state_e S_NEXT_INSTR = S_WAIT;
`else
    localparam state_e S_NEXT_INSTR = S_T0;
`endif

    typedef enum logic [3:0] {
        CL_NONE, CL_RTYPE, CL_IMM, CL_LD, CL_ST, CL_MULDIV, CL_UNARY,
        CL_BR, CL_JR, CL_MFHI, CL_MFLO, CL_IN, CL_HALT
    } class_e;

    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        case (op)
            OP_ANDI: imm_alu_op = OP_AND;
            OP_ORI:  imm_alu_op = OP_OR;
            default: imm_alu_op = OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instruction class and the last execute step of that class.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output class_e     cls_o,
    output state_e     last_o
);

    always_comb begin
        cls_o = CL_NONE;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:      cls_o = CL_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:     cls_o = CL_IMM;
            OP_LD:                                cls_o = CL_LD;
            OP_ST:                                cls_o = CL_ST;
            OP_MUL, OP_DIV:                       cls_o = CL_MULDIV;
            OP_NEG, OP_NOT:                       cls_o = CL_UNARY;
            OP_BR:                                cls_o = CL_BR;
            OP_JR:                                cls_o = CL_JR;
            OP_MFHI:                              cls_o = CL_MFHI;
            OP_MFLO:                              cls_o = CL_MFLO;
            OP_IN:                                cls_o = CL_IN;
            OP_HALT:                              cls_o = CL_HALT;
            default:                              cls_o = CL_NONE;
        endcase
    end

    // br idles through T7 so that it occupies eight cycles like ld/st
    always_comb begin
        last_o = S_T3;
        case (cls_o)
            CL_RTYPE, CL_IMM:     last_o = S_T5;
            CL_LD, CL_ST, CL_BR:  last_o = S_T7;
            CL_MULDIV:            last_o = S_T6;
            CL_UNARY:             last_o = S_T4;
            default:              last_o = S_T3;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, then opcode-specific execute steps.
// CTRL_STEP_EN: park in WAIT after every instruction until a step pulse.
//
// state  | meaning
// T0-T2  | fetch: PC to MAR, memory read, MDR to IR
// T3-T7  | execute steps, length set by instruction class
// HALT   | stopped, run = 0, left only by clr
// WAIT   | single-step hold between instructions (CTRL_STEP_EN only)
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        step,
    output logic        run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        IncPC,
    output logic        PCin,
    output logic        MARin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        MDRin,
    output logic        MDRread,
    output logic        MDRout,
    output logic        WRen,
    output logic        ZLowSelect,
    output logic        ZLOout,
    output logic        ZHighSelect,
    output logic        ZHIout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        InPortout,
    output logic        CON_ff_in,
    output logic [4:0]  ALU_opcode
);

    state_e     state_q, state_d;
    logic       live_q;
    logic [4:0] op;
    class_e     cls;
    state_e     last_step;
    logic       unused_ok;

    assign op        = ir[31:27];
    assign unused_ok = ^{ir[26:0], step};

    ctrl_decode u_decode (
        .opcode_i (op),
        .cls_o    (cls),
        .last_o   (last_step)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALT: state_d = S_HALT;
`ifdef CTRL_STEP_EN
            S_WAIT: if (step) state_d = S_T0;
`endif
            default: begin
                if (state_q == S_T3 && cls == CL_HALT)
                    state_d = S_HALT;
                else if (state_q == last_step)
                    state_d = S_NEXT_INSTR;
                else
                    state_d = state_e'(state_q + 4'd1);
            end
        endcase
    end

    // live_q holds the FSM in T0 with outputs off for the first edge after clr is released
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_T0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (live_q)
                state_q <= state_d;
        end
    end

    always_comb begin
        run = 1'b0;  Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;  Rin = 1'b0;  Rout = 1'b0;
        BAout = 1'b0;  PCout = 1'b0;  IncPC = 1'b0;  PCin = 1'b0;  MARin = 1'b0;
        IRin = 1'b0;  Yin = 1'b0;  Zin = 1'b0;  MDRin = 1'b0;  MDRread = 1'b0;
        MDRout = 1'b0;  WRen = 1'b0;  ZLowSelect = 1'b0;  ZLOout = 1'b0;
        ZHighSelect = 1'b0;  ZHIout = 1'b0;  HIin = 1'b0;  LOin = 1'b0;
        HIout = 1'b0;  LOout = 1'b0;  Cout = 1'b0;  InPortout = 1'b0;
        CON_ff_in = 1'b0;  ALU_opcode = 5'd0;
        if (live_q && state_q != S_HALT) begin
            run = 1'b1;
            case (state_q)
                S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
                S_T1: begin MDRread = 1'b1; MDRin = 1'b1; end
                S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
                S_T3: begin
                    case (cls)
                        CL_RTYPE, CL_IMM: begin
                            Grb = 1'b1; Yin = 1'b1;
                            if (op == OP_LDI) BAout = 1'b1;
                            else Rout = 1'b1;
                        end
                        CL_LD, CL_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                        CL_MULDIV:     begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        CL_UNARY:      begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = op; end
                        CL_BR:         begin Gra = 1'b1; Rout = 1'b1; CON_ff_in = 1'b1; end
                        CL_JR:         begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        CL_MFHI:       begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CL_MFLO:       begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CL_IN:         begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default:       ;
                    endcase
                end
                S_T4: begin
                    case (cls)
                        CL_RTYPE:     begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = op; end
                        CL_IMM:       begin Cout = 1'b1; Zin = 1'b1; ALU_opcode = imm_alu_op(op); end
                        CL_LD, CL_ST: begin Cout = 1'b1; Zin = 1'b1; ALU_opcode = OP_ADD; end
                        CL_MULDIV:    begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = op; end
                        CL_UNARY:     begin ZLowSelect = 1'b1; ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CL_BR:        begin PCout = 1'b1; Yin = 1'b1; end
                        default:      ;
                    endcase
                end
                S_T5: begin
                    case (cls)
                        CL_RTYPE, CL_IMM: begin ZLowSelect = 1'b1; ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CL_LD, CL_ST:     begin ZLowSelect = 1'b1; ZLOout = 1'b1; MARin = 1'b1; end
                        CL_MULDIV:        begin ZLowSelect = 1'b1; ZLOout = 1'b1; LOin = 1'b1; end
                        CL_BR:            begin Cout = 1'b1; Zin = 1'b1; ALU_opcode = OP_ADD; end
                        default:          ;
                    endcase
                end
                S_T6: begin
                    case (cls)
                        CL_LD:     begin MDRread = 1'b1; MDRin = 1'b1; end
                        CL_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                        CL_MULDIV: begin ZHighSelect = 1'b1; ZHIout = 1'b1; HIin = 1'b1; end
                        CL_BR: if (con_ff) begin
                            ZLowSelect = 1'b1; ZLOout = 1'b1; PCin = 1'b1;
                        end
                        default:   ;
                    endcase
                end
                S_T7: begin
                    case (cls)
                        CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CL_ST:   WRen = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues per-cycle expected strobes, a monitor compares.
`timescale 1ns/1ps
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr, con_ff, step;
   logic [31:0] ir;
   logic run, Gra, Grb, Grc, Rin, Rout, BAout, PCout, IncPC, PCin, MARin, IRin, Yin, Zin;
   logic MDRin, MDRread, MDRout, WRen, ZLowSelect, ZLOout, ZHighSelect, ZHIout;
   logic HIin, LOin, HIout, LOout, Cout, InPortout, CON_ff_in;
   logic [4:0] ALU_opcode;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .step(step), .run(run),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .IRin(IRin),
      .Yin(Yin), .Zin(Zin), .MDRin(MDRin), .MDRread(MDRread), .MDRout(MDRout),
      .WRen(WRen), .ZLowSelect(ZLowSelect), .ZLOout(ZLOout), .ZHighSelect(ZHighSelect),
      .ZHIout(ZHIout), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
      .Cout(Cout), .InPortout(InPortout), .CON_ff_in(CON_ff_in), .ALU_opcode(ALU_opcode)
   );

   logic [33:0] obs;
   assign obs = {run, Gra, Grb, Grc, Rin, Rout, BAout, PCout, IncPC, PCin, MARin, IRin,
                 Yin, Zin, MDRin, MDRread, MDRout, WRen, ZLowSelect, ZLOout, ZHighSelect,
                 ZHIout, HIin, LOin, HIout, LOout, Cout, InPortout, CON_ff_in, ALU_opcode};

   localparam logic [33:0] RUN   = 34'd1 << 33, GRA   = 34'd1 << 32, GRB   = 34'd1 << 31;
   localparam logic [33:0] GRC   = 34'd1 << 30, RIN   = 34'd1 << 29, ROUT  = 34'd1 << 28;
   localparam logic [33:0] BAOUT = 34'd1 << 27, PCOUT = 34'd1 << 26, INCPC = 34'd1 << 25;
   localparam logic [33:0] PCIN  = 34'd1 << 24, MARIN = 34'd1 << 23, IRIN  = 34'd1 << 22;
   localparam logic [33:0] YIN   = 34'd1 << 21, ZIN   = 34'd1 << 20, MDRIN = 34'd1 << 19;
   localparam logic [33:0] MDRRD = 34'd1 << 18, MDROUT = 34'd1 << 17, WREN = 34'd1 << 16;
   localparam logic [33:0] ZLO   = (34'd1 << 15) | (34'd1 << 14);
   localparam logic [33:0] ZHI   = (34'd1 << 13) | (34'd1 << 12);
   localparam logic [33:0] HIIN  = 34'd1 << 11, LOIN  = 34'd1 << 10, HIOUT = 34'd1 << 9;
   localparam logic [33:0] LOOUT = 34'd1 << 8,  COUT  = 34'd1 << 7,  INPORT = 34'd1 << 6;
   localparam logic [33:0] CONIN = 34'd1 << 5;

   function automatic logic [33:0] alu(input logic [4:0] v);
      return {29'd0, v};
   endfunction

   string       tag_q[$];
   logic [33:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;

   // expectation for the cycle that has just begun, then advance to the next one
   task automatic cyc(input string tag, input logic [33:0] e);
      tag_q.push_back(tag);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         string       t;
         logic [33:0] e;
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", t, obs, e);
         end
      end
   end

   task automatic fetch(input string name);
      cyc({name, "_T0"}, RUN | PCOUT | MARIN | INCPC);
      cyc({name, "_T1"}, RUN | MDRRD | MDRIN);
      cyc({name, "_T2"}, RUN | MDROUT | IRIN);
   endtask

   task automatic end_instr();
`ifdef CTRL_STEP_EN
      repeat (5) cyc("wait_hold", RUN);
      step = 1'b1;
      cyc("wait_step", RUN);
      step = 1'b0;
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      clr = 1'b0; ir = 32'h18918000; con_ff = 1'b0; step = 1'b0;
      @(posedge clk);
      #1;
      repeat (3) cyc("reset", 34'd0);
      clr = 1'b1;
      cyc("release", 34'd0);

      checks++;
      if (PCout !== 1'b1 || MARin !== 1'b1 || IncPC !== 1'b1) begin
         failures++;
         $display("FAIL first_T0: PCout=%b MARin=%b IncPC=%b", PCout, MARin, IncPC);
      end

      // add R1,R2,R3; step pulse in T4 must be ignored
      fetch("add");
      cyc("add_T3", RUN | GRB | ROUT | YIN);
      step = 1'b1;
      cyc("add_T4", RUN | GRC | ROUT | ZIN | alu(5'b00011));
      step = 1'b0;
      cyc("add_T5", RUN | ZLO | GRA | RIN);
      end_instr();

      ir = 32'h10800010;
      fetch("st");
      cyc("st_T3", RUN | GRB | BAOUT | YIN);
      cyc("st_T4", RUN | COUT | ZIN | alu(5'b00011));
      cyc("st_T5", RUN | ZLO | MARIN);
      checks++;
      if (MDRread !== 1'b0) begin
         failures++;
         $display("FAIL st_T6_mdrread: MDRread=%b", MDRread);
      end
      cyc("st_T6", RUN | GRA | ROUT | MDRIN);
      checks++;
      if (WRen !== 1'b1) begin
         failures++;
         $display("FAIL st_T7_wren: WRen=%b", WRen);
      end
      cyc("st_T7", RUN | WREN);
      end_instr();

      ir = 32'h00800010;
      fetch("ld");
      cyc("ld_T3", RUN | GRB | BAOUT | YIN);
      cyc("ld_T4", RUN | COUT | ZIN | alu(5'b00011));
      cyc("ld_T5", RUN | ZLO | MARIN);
      cyc("ld_T6", RUN | MDRRD | MDRIN);
      cyc("ld_T7", RUN | MDROUT | GRA | RIN);
      end_instr();

      ir = 32'h98800004;
      for (int k = 0; k < 2; k++) begin
         con_ff = (k == 1);
         fetch("br");
         cyc("br_T3", RUN | GRA | ROUT | CONIN);
         cyc("br_T4", RUN | PCOUT | YIN);
         cyc("br_T5", RUN | COUT | ZIN | alu(5'b00011));
         cyc(k == 1 ? "br_T6_taken" : "br_T6_not", (k == 1) ? (RUN | ZLO | PCIN) : RUN);
         cyc("br_T7", RUN);
         end_instr();
      end
      con_ff = 1'b0;

      ir = 32'h80000000;
      fetch("mul");
      cyc("mul_T3", RUN | GRA | ROUT | YIN);
      cyc("mul_T4", RUN | GRB | ROUT | ZIN | alu(5'b10000));
      cyc("mul_T5", RUN | ZLO | LOIN);
      cyc("mul_T6", RUN | ZHI | HIIN);
      end_instr();

      ir = 32'h88000000;
      fetch("neg");
      cyc("neg_T3", RUN | GRB | ROUT | ZIN | alu(5'b10001));
      cyc("neg_T4", RUN | ZLO | GRA | RIN);
      end_instr();

      ir = 32'h08000000;
      fetch("ldi");
      cyc("ldi_T3", RUN | GRB | BAOUT | YIN);
      cyc("ldi_T4", RUN | COUT | ZIN | alu(5'b00011));
      cyc("ldi_T5", RUN | ZLO | GRA | RIN);
      end_instr();

      ir = 32'h68000000;
      fetch("andi");
      cyc("andi_T3", RUN | GRB | ROUT | YIN);
      cyc("andi_T4", RUN | COUT | ZIN | alu(5'b00101));
      cyc("andi_T5", RUN | ZLO | GRA | RIN);
      end_instr();

      ir = 32'hC0000000;
      fetch("mfhi");
      cyc("mfhi_T3", RUN | HIOUT | GRA | RIN);
      end_instr();

      ir = 32'hA0000000;
      fetch("jr");
      cyc("jr_T3", RUN | GRA | ROUT | PCIN);
      end_instr();

      ir = 32'hF8000000;
      fetch("undef");
      cyc("undef_T3", RUN);
      end_instr();

      ir = 32'hD0000000;
      fetch("nop");
      cyc("nop_T3", RUN);
      end_instr();

      // st abandoned in T6 by reset: no MDRin/WRen may appear
      ir = 32'h10800010;
      fetch("st_abort");
      cyc("st_abort_T3", RUN | GRB | BAOUT | YIN);
      cyc("st_abort_T4", RUN | COUT | ZIN | alu(5'b00011));
      cyc("st_abort_T5", RUN | ZLO | MARIN);
      clr = 1'b0;
      repeat (2) cyc("st_abort_clr", 34'd0);
      clr = 1'b1;
      cyc("st_abort_release", 34'd0);

      ir = 32'hD8000000;
      fetch("halt");
      cyc("halt_T3", RUN);
      for (int k = 0; k < 20; k++) begin
         step = k[0];
         cyc("halted", 34'd0);
      end
      checks++;
      if (run !== 1'b0) begin
         failures++;
         $display("FAIL halt_run: run=%b", run);
      end
      step = 1'b0;
      clr = 1'b0;
      cyc("halt_clr", 34'd0);
      clr = 1'b1;
      cyc("halt_release", 34'd0);
      checks++;
      if (PCout !== 1'b1 || run !== 1'b1) begin
         failures++;
         $display("FAIL halt_restart: PCout=%b run=%b", PCout, run);
      end

      ir = 32'hB0000000;
      fetch("in");
      cyc("in_T3", RUN | INPORT | GRA | RIN);
      end_instr();
      fetch("in_again");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
